// File: rtl/lsu_mem_master_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and default sizing for the load/store unit memory master.
//   size_t  : CPU access size encoding (2'b11 is not a legal size)
//   state_t : sequencing states of the memory master
//   LSU_BASE_ADDR / LSU_DEPTH_WORDS : default placement of the data window
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    localparam logic [31:0] LSU_BASE_ADDR   = 32'h3E0;
    localparam int unsigned LSU_DEPTH_WORDS = 128;

endpackage

// File: rtl/lsu_mem_master_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_master_if
// Bundles the CPU request/response handshake and the word-wide memory port.
//   master modport : the load/store unit (drives req_ready, resp_*, WE/RE/A/WD)
//   slave  modport : the CPU + memory side (drives req_*, RD)
// req_size carries an lsu_pkg::size_t encoding; it is kept as a raw 2-bit
// vector so the illegal 2'b11 code can travel on the bus and be rejected.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface lsu_mem_master_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        WE;
    logic        RE;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, RD,
        output req_ready, resp_valid, resp_rdata, resp_err, WE, RE, A, WD
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, RD,
        input  req_ready, resp_valid, resp_rdata, resp_err, WE, RE, A, WD
    );

endinterface

// File: rtl/lsu_mem_master_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational little-endian lane handling.
//   size        in  2  access size (size_t encoding)
//   is_unsigned in  1  zero-extend loads when 1, sign-extend when 0
//   lane        in  2  byte offset within the word (addr[1:0])
//   mem_word    in  32 word read from memory
//   st_data     in  32 right-aligned store data
//   ld_data     out 32 selected lane, right-aligned and extended
//   st_word     out 32 mem_word with the addressed lane(s) replaced by st_data
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  lane,
    input  logic [31:0] mem_word,
    input  logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_word[7:0];
        case (lane)
            2'd0: byte_sel = mem_word[7:0];
            2'd1: byte_sel = mem_word[15:8];
            2'd2: byte_sel = mem_word[23:16];
            2'd3: byte_sel = mem_word[31:24];
            default: byte_sel = mem_word[7:0];
        endcase
        // Halfwords are only ever issued aligned, so lane[1] picks the half.
        half_sel = lane[1] ? mem_word[31:16] : mem_word[15:0];
    end

    always_comb begin
        ld_data = mem_word;
        case (size)
            SZ_BYTE: ld_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SZ_HALF: ld_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default: ld_data = mem_word;
        endcase
    end

    always_comb begin
        st_word = mem_word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0: st_word = {mem_word[31:8], st_data[7:0]};
                    2'd1: st_word = {mem_word[31:16], st_data[7:0], mem_word[7:0]};
                    2'd2: st_word = {mem_word[31:24], st_data[7:0], mem_word[15:0]};
                    2'd3: st_word = {st_data[7:0], mem_word[23:0]};
                    default: st_word = mem_word;
                endcase
            end
            SZ_HALF: st_word = lane[1] ? {st_data[15:0], mem_word[15:0]}
                                       : {mem_word[31:16], st_data[15:0]};
            default: st_word = st_data;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// -----------------------------------------------------------------------------
// lsu_mem_master
// Initiator side of the data-memory port. Accepts byte/half/word loads and
// stores addressed by byte offset, drives a word-wide memory port and does
// read-modify-write for sub-word stores. One request is in flight at a time.
//   clk  in   system clock, rising edge
//   rst  in   asynchronous active-high reset
//   bus  master modport of lsu_mem_master_if:
//        req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/req_wdata
//        resp_valid/resp_rdata/resp_err
//        WE/RE/A/WD (registered) and RD (combinational from A and RE)
// Sequencing: IDLE -> READ -> RESP          (load)
//             IDLE -> READ -> WRITE -> RESP (sub-word store)
//             IDLE -> WRITE -> RESP         (word store)
//             IDLE -> RESP                  (misaligned / out-of-range)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = LSU_BASE_ADDR,
    parameter int unsigned DEPTH_WORDS = LSU_DEPTH_WORDS
) (
    input  logic             clk,
    input  logic             rst,
    lsu_mem_master_if.master bus
);

    localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic        re_q, re_d;
    logic [31:0] a_q, a_d;
    logic [31:0] wd_q, wd_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    // Request fields captured at acceptance.
    logic        op_we_q, op_we_d;
    logic [1:0]  op_size_q, op_size_d;
    logic        op_uns_q, op_uns_d;
    logic [1:0]  op_lane_q, op_lane_d;
    logic [31:0] op_wdata_q, op_wdata_d;

    logic        accept;
    logic        misaligned;
    logic        out_of_range;
    logic [31:0] word_addr;
    logic [31:0] ld_data;
    logic [31:0] st_word;

    assign bus.req_ready  = (state_q == IDLE) && !rst;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.WE         = we_q;
    assign bus.RE         = re_q;
    assign bus.A          = a_q;
    assign bus.WD         = wd_q;

    assign accept       = bus.req_valid && (state_q == IDLE);
    assign out_of_range = bus.req_addr >= BYTE_LIMIT;
    assign word_addr    = BASE_ADDR + {2'b00, bus.req_addr[31:2]};

    always_comb begin
        misaligned = 1'b1;
        case (bus.req_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = bus.req_addr[0];
            SZ_WORD: misaligned = |bus.req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // The lane logic always looks at RD; its outputs are only consumed in READ,
    // which is the only state where RE is high and RD is meaningful.
    lsu_align u_align (
        .size        (op_size_q),
        .is_unsigned (op_uns_q),
        .lane        (op_lane_q),
        .mem_word    (bus.RD),
        .st_data     (op_wdata_q),
        .ld_data     (ld_data),
        .st_word     (st_word)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = 1'b0;
        re_d         = 1'b0;
        a_d          = a_q;
        wd_d         = wd_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        op_we_d      = op_we_q;
        op_size_d    = op_size_q;
        op_uns_d     = op_uns_q;
        op_lane_d    = op_lane_q;
        op_wdata_d   = op_wdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_we_d    = bus.req_we;
                    op_size_d  = bus.req_size;
                    op_uns_d   = bus.req_unsigned;
                    op_lane_d  = bus.req_addr[1:0];
                    op_wdata_d = bus.req_wdata;
                    if (misaligned || out_of_range) begin
                        // Rejected requests never touch the memory port.
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else if (bus.req_we && (bus.req_size == SZ_WORD)) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        a_d     = word_addr;
                        wd_d    = bus.req_wdata;
                    end else begin
                        state_d = READ;
                        re_d    = 1'b1;
                        a_d     = word_addr;
                    end
                end
            end
            READ: begin
                if (op_we_q) begin
                    state_d = WRITE;
                    we_d    = 1'b1;
                    wd_d    = st_word;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ld_data;
                end
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            re_q         <= 1'b0;
            a_q          <= BASE_ADDR;
            wd_q         <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            op_we_q      <= 1'b0;
            op_size_q    <= 2'b00;
            op_uns_q     <= 1'b0;
            op_lane_q    <= 2'b00;
            op_wdata_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            re_q         <= re_d;
            a_q          <= a_d;
            wd_q         <= wd_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            op_we_q      <= op_we_d;
            op_size_q    <= op_size_d;
            op_uns_q     <= op_uns_d;
            op_lane_q    <= op_lane_d;
            op_wdata_q   <= op_wdata_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_master
// Bench for lsu_mem_master: a word-array memory model on the memory port and
// an arithmetic reference model of byte-addressed loads/stores.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lsu_mem_master;

    localparam logic [31:0] BASE  = 32'h3E0;
    localparam int          DEPTH = 128;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          re_cyc;
        int          we_cyc;
        logic [31:0] re_a;
        logic [31:0] we_a;
        logic [31:0] we_d;
        logic        busy_rdy;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    lsu_mem_master_if bus ();

    lsu_mem_master #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Memory: combinational read, write committed on the falling edge.
    assign bus.RD = bus.RE ? mem[7'(bus.A - BASE)] : 32'h0;
    always @(negedge clk) if (bus.WE) mem[7'(bus.A - BASE)] <= bus.WD;

    // ---------------- reference model ----------------
    function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] addr);
        if (sz == 2'd3) return 1'b1;
        if (addr >= 32'(4 * DEPTH)) return 1'b1;
        return (addr % (32'd1 << sz)) != 32'd0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] sz,
                                             input logic uns, input logic [1:0] off);
        longint bits, v;
        bits = longint'(8) << sz;
        v = longint'(word >> (8 * off)) % (longint'(1) << bits);
        if (!uns && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] mask;
        mask = 32'(((longint'(1) << (longint'(8) << sz)) - 1) << (8 * off));
        return (word & ~mask) | (32'(longint'(wdata) << (8 * off)) & mask);
    endfunction

    // ---------------- transaction driver ----------------
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, output obs_t o);
        int w;
        o.rdata = 32'h0; o.err = 1'b0; o.lat = 0; o.re_cyc = 0; o.we_cyc = 0;
        o.re_a = 32'h0; o.we_a = 32'h0; o.we_d = 32'h0; o.busy_rdy = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
        w = 0;
        while (!bus.req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.req_ready) o.busy_rdy = 1'b1;
            if (bus.RE) begin o.re_cyc++; o.re_a = bus.A; end
            if (bus.WE) begin o.we_cyc++; o.we_a = bus.A; o.we_d = bus.WD; end
            if (bus.resp_valid) begin
                o.lat = k; o.rdata = bus.resp_rdata; o.err = bus.resp_err;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
        n_tests++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err got=%b exp=0", bus.resp_err); end
        n_tests++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata got=%h exp=0", bus.resp_rdata); end
        n_tests++; if (bus.WE !== 1'b0 || bus.RE !== 1'b0) begin n_fail++; $display("FAIL reset_we_re got=%b%b exp=00", bus.WE, bus.RE); end
        n_tests++; if (bus.A !== BASE) begin n_fail++; $display("FAIL reset_A got=%h exp=%h", bus.A, BASE); end
        n_tests++; if (bus.WD !== 32'h0) begin n_fail++; $display("FAIL reset_WD got=%h exp=0", bus.WD); end
        rst = 1'b0;
        #1;
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    endtask

    // Word stores that also initialise words 0..15 and 127.
    task automatic test_word_store();
        obs_t o;
        logic [31:0] d, addr;
        for (int i = 0; i < 17; i++) begin
            addr = (i == 16) ? 32'h1FC : 32'(i * 4);
            d = (i == 0) ? 32'hAABBCCDD : $urandom;
            do_req(1'b1, 2'd2, 1'b0, addr, d, o);
            ref_mem[addr >> 2] = d;
            n_tests++;
            if (o.lat != 2 || o.we_cyc != 1 || o.re_cyc != 0 || o.err !== 1'b0 ||
                o.we_a !== BASE + (addr >> 2) || o.we_d !== d || o.rdata !== 32'h0 || o.busy_rdy) begin
                n_fail++;
                $display("FAIL word_store[%0d] got lat=%0d we=%0d re=%0d err=%b A=%h WD=%h rd=%h busy=%b exp lat=2 we=1 re=0 err=0 A=%h WD=%h rd=0 busy=0",
                         i, o.lat, o.we_cyc, o.re_cyc, o.err, o.we_a, o.we_d, o.rdata, o.busy_rdy, BASE + (addr >> 2), d);
            end
        end
        // The 0x20 store from the list of directed scenarios.
        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h21212121, o);
        ref_mem[8] = 32'h21212121;
        n_tests++;
        if (o.we_a !== 32'h3E8 || o.we_d !== 32'h21212121 || o.re_cyc != 0 || o.we_cyc != 1 || o.lat != 2) begin
            n_fail++;
            $display("FAIL word_store_0x20 got A=%h WD=%h re=%0d we=%0d lat=%0d exp A=3e8 WD=21212121 re=0 we=1 lat=2",
                     o.we_a, o.we_d, o.re_cyc, o.we_cyc, o.lat);
        end
    endtask

    task automatic test_load_directed();
        obs_t o;
        do_req(1'b0, 2'd0, 1'b1, 32'h1, 32'h0, o);
        n_tests++;
        if (o.rdata !== 32'h000000CC || o.lat != 2 || o.we_cyc != 0 || o.re_cyc != 1 || o.re_a !== BASE) begin
            n_fail++;
            $display("FAIL load_bu_1 got rd=%h lat=%0d we=%0d re=%0d A=%h exp rd=000000cc lat=2 we=0 re=1 A=%h",
                     o.rdata, o.lat, o.we_cyc, o.re_cyc, o.re_a, BASE);
        end
        do_req(1'b0, 2'd0, 1'b0, 32'h3, 32'h0, o);
        n_tests++; if (o.rdata !== 32'hFFFFFFAA) begin n_fail++; $display("FAIL load_bs_3 got=%h exp=ffffffaa", o.rdata); end
        do_req(1'b0, 2'd1, 1'b0, 32'h2, 32'h0, o);
        n_tests++; if (o.rdata !== 32'hFFFFAABB) begin n_fail++; $display("FAIL load_hs_2 got=%h exp=ffffaabb", o.rdata); end
        do_req(1'b0, 2'd1, 1'b1, 32'h2, 32'h0, o);
        n_tests++; if (o.rdata !== 32'h0000AABB) begin n_fail++; $display("FAIL load_hu_2 got=%h exp=0000aabb", o.rdata); end
    endtask

    task automatic test_subword_store();
        obs_t o;
        do_req(1'b1, 2'd1, 1'b0, 32'h2, 32'h00001234, o);
        ref_mem[0] = 32'h1234CCDD;
        n_tests++;
        if (o.re_cyc != 1 || o.we_cyc != 1 || o.we_a !== 32'h3E0 || o.we_d !== 32'h1234CCDD || o.lat != 3 || o.err !== 1'b0) begin
            n_fail++;
            $display("FAIL store_half_2 got re=%0d we=%0d A=%h WD=%h lat=%0d err=%b exp re=1 we=1 A=3e0 WD=1234ccdd lat=3 err=0",
                     o.re_cyc, o.we_cyc, o.we_a, o.we_d, o.lat, o.err);
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, o);
        n_tests++; if (o.rdata !== 32'h1234CCDD) begin n_fail++; $display("FAIL readback_word0 got=%h exp=1234ccdd", o.rdata); end
        // Top byte of the window.
        do_req(1'b1, 2'd0, 1'b0, 32'h1FF, 32'hFFFFFFA5, o);
        ref_mem[127] = ref_merge(ref_mem[127], 32'hFFFFFFA5, 2'd0, 2'd3);
        do_req(1'b0, 2'd0, 1'b0, 32'h1FF, 32'h0, o);
        n_tests++; if (o.rdata !== 32'hFFFFFFA5 || o.err !== 1'b0) begin n_fail++; $display("FAIL top_byte got rd=%h err=%b exp rd=ffffffa5 err=0", o.rdata, o.err); end
    endtask

    task automatic test_errors();
        obs_t o;
        logic [1:0]  sz_t [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [31:0] ad_t [4] = '{32'h1, 32'h200, 32'h4, 32'hFFFF_FFFC};
        logic        we_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            do_req(we_t[i], sz_t[i], 1'b0, ad_t[i], 32'h55AA55AA, o);
            n_tests++;
            if (o.err !== 1'b1 || o.lat != 1 || o.re_cyc != 0 || o.we_cyc != 0 || o.rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL error_case[%0d] got err=%b lat=%0d re=%0d we=%0d rd=%h exp err=1 lat=1 re=0 we=0 rd=0",
                         i, o.err, o.lat, o.re_cyc, o.we_cyc, o.rdata);
            end
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic        we, uns, e;
        logic [1:0]  sz;
        logic [31:0] addr, wdata, exp_rd, exp_wd;
        int          exp_lat, exp_re, exp_we, widx;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) sz = 2'd3;
            addr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) addr = 32'h200 + 32'($urandom_range(0, 4095));
            wdata = $urandom;
            e = ref_err(sz, addr);
            widx = int'(addr >> 2) % DEPTH;
            exp_rd = 32'h0; exp_wd = 32'h0;
            if (e) begin
                exp_lat = 1; exp_re = 0; exp_we = 0;
            end else begin
                exp_re = (!we || sz != 2'd2) ? 1 : 0;
                exp_we = we ? 1 : 0;
                exp_lat = (we && sz != 2'd2) ? 3 : 2;
                if (we) exp_wd = ref_merge(ref_mem[widx], wdata, sz, addr[1:0]);
                else    exp_rd = ref_load(ref_mem[widx], sz, uns, addr[1:0]);
            end
            do_req(we, sz, uns, addr, wdata, o);
            if (!e && we) ref_mem[widx] = exp_wd;
            n_tests++;
            if (o.err !== e || o.lat != exp_lat || o.re_cyc != exp_re || o.we_cyc != exp_we ||
                o.rdata !== exp_rd || o.busy_rdy ||
                (exp_we == 1 && (o.we_d !== exp_wd || o.we_a !== BASE + (addr >> 2))) ||
                (exp_re == 1 && o.re_a !== BASE + (addr >> 2))) begin
                n_fail++;
                $display("FAIL random[%0d] we=%b sz=%0d uns=%b addr=%h got err=%b lat=%0d re=%0d we=%0d rd=%h WD=%h A=%h busy=%b exp err=%b lat=%0d re=%0d we=%0d rd=%h WD=%h",
                         i, we, sz, uns, addr, o.err, o.lat, o.re_cyc, o.we_cyc, o.rdata, o.we_d, o.we_a, o.busy_rdy,
                         e, exp_lat, exp_re, exp_we, exp_rd, exp_wd);
            end
        end
        for (int j = 0; j < 16; j++) begin
            n_tests++;
            if (mem[j] !== ref_mem[j]) begin n_fail++; $display("FAIL mem_word[%0d] got=%h exp=%h", j, mem[j], ref_mem[j]); end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        logic saw_we, saw_rv;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h5; bus.req_wdata = 32'h77;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n_tests++; if (bus.RE !== 1'b1) begin n_fail++; $display("FAIL mid_read_entry RE got=%b exp=1", bus.RE); end
        #1 rst = 1'b1;
        #1;
        n_tests++; if (bus.RE !== 1'b0 || bus.WE !== 1'b0) begin n_fail++; $display("FAIL mid_async_drop got RE=%b WE=%b exp 0 0", bus.RE, bus.WE); end
        saw_we = 1'b0; saw_rv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.WE) saw_we = 1'b1;
            if (bus.resp_valid) saw_rv = 1'b1;
            if (k == 1) rst = 1'b0;
        end
        n_tests++; if (saw_we || saw_rv) begin n_fail++; $display("FAIL mid_no_activity got WE=%b resp_valid=%b exp 0 0", saw_we, saw_rv); end
        n_tests++; if (mem[1] !== ref_mem[1]) begin n_fail++; $display("FAIL mid_mem_unchanged got=%h exp=%h", mem[1], ref_mem[1]); end
        do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, o);
        n_tests++;
        if (o.rdata !== ref_mem[1] || o.lat != 2 || o.err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after_reset got rd=%h lat=%0d err=%b exp rd=%h lat=2 err=0", o.rdata, o.lat, o.err, ref_mem[1]);
        end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_load_directed();
        test_subword_store();
        test_errors();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
Load/store unit: the initiator side of the data-memory port. It accepts byte, halfword and word load/store requests from the CPU datapath using byte addresses. It drives the word-wide memory port (WE, RE, A, WD, RD) and performs read-modify-write for sub-word stores. Responses return to the CPU with sign or zero extension.

Parameters:
BASE_ADDR, 32'h3E0, word address on the memory port that maps to byte offset 0
DEPTH_WORDS, 128, number of 32-bit words in the data window; byte window is 4*DEPTH_WORDS

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  CPU request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_size  in  2  access size (lsu_pkg size_t)
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  32  byte offset within the data window
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle pulse: access complete
resp_rdata  out  32  extended load data (0 for stores and errors)
resp_err  out  1  qualified by resp_valid: misaligned or out-of-range request
WE  out  1  memory write enable
RE  out  1  memory read enable
A  out  32  memory word address
WD  out  32  memory write data
RD  in  32  memory read data, combinational from A and RE

Behaviour:
- Reset (async) forces state=IDLE and drives resp_valid=0, resp_err=0, resp_rdata=0, WE=0, RE=0, A=BASE_ADDR, WD=0. req_ready=1 once rst deasserts.
- Handshake: a request is accepted on a rising edge with req_valid && req_ready. All request fields are latched at acceptance. The CPU holds the fields until acceptance.
- Checks at accept:
  - Misaligned: half with addr[0]!=0, or word with addr[1:0]!=0.
  - Out of range: addr >= 4*DEPTH_WORDS.
  - size=2'b11 counts as misaligned.
  - Either condition -> state RESP with resp_err=1. No WE or RE is ever asserted for the request.
- Address: A = BASE_ADDR + addr[31:2]. A, WE, RE and WD are registered and remain stable for the whole cycle. The memory commits writes on the falling edge inside the WE cycle.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE -> READ on load or sub-word store.
  - IDLE -> WRITE on word store.
  - IDLE -> RESP on error.
  - READ: RE=1. RD is sampled at the rising edge that ends the cycle.
    - A load goes to RESP with the extracted lane.
    - A sub-word store merges req_wdata into the captured word and goes to WRITE.
  - WRITE: WE=1 for exactly one cycle, WD = full or merged word -> RESP.
  - RESP: resp_valid=1 for one cycle -> IDLE.
- Latency from accept edge to resp_valid: load 2 cycles; word store 2; sub-word store 3; error 1.
- Byte lanes are little-endian.
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Load data is right-aligned, then sign- or zero-extended to 32 bits.
  - Store merge replaces only the addressed lane(s) and keeps the other bytes from the READ capture.
- No back-to-back accept: req_ready=0 from accept until the cycle after RESP.
- Reset mid-operation: WE and RE drop asynchronously and no response is issued. A WRITE cleared before its falling edge does not commit. This is accepted behaviour.
- Outside READ and WRITE: RE=0, WE=0; A and WD hold their last value.

Decomposition:
- lsu_pkg holds:
  - typedef enum logic[1:0] size_t {SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10}
  - typedef enum state_t {IDLE, READ, WRITE, RESP}
  - BASE_ADDR and DEPTH_WORDS defaults
- One combinational sub-module, lsu_align:
  - Inputs: size, unsigned flag, addr[1:0], a memory word, store data.
  - Outputs: extended load data and merged store word.
- lsu_mem_master keeps the FSM, checks and registers.

Test Plan:
- Word 0 = 0xAABBCCDD; load byte unsigned addr 1 -> resp_rdata=0x000000CC, 2 cycles after accept, WE never high.
- Word 0 = 0xAABBCCDD; load byte signed addr 3 -> resp_rdata=0xFFFFFFAA; load half signed addr 2 -> 0xFFFFAABB.
- Store half 0x00001234 at addr 2 into word 0 = 0xAABBCCDD -> one RE cycle, then one WE cycle with A=0x3E0, WD=0x1234CCDD; readback word=0x1234CCDD; resp_valid 3 cycles after accept.
- Store word 0x21212121 at addr 0x20 -> single WE cycle, A=0x3E8, WD=0x21212121, RE never high.
- Load half at addr 1, and load word at addr 0x200 -> resp_err=1 one cycle after accept; RE and WE stay 0; resp_rdata=0.
- Assert rst during the READ cycle of a sub-word store -> WE never asserted, memory word unchanged, no resp_valid; a new request is accepted after rst deasserts.
